// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop, LSB first.
// A result appears WIDTH+1 cycles after start is accepted; s/cout/ovf hold until the next one.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for start, operands captured on acceptance
    // RUN   | one bit per cycle, exactly WIDTH cycles
    // FIN   | result registered, done pulses for this single cycle

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, work;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum_bit, carry_nx, last_bit;

    assign sum_bit  = op_a[0] ^ op_b[0] ^ carry;
    assign carry_nx = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    work  <= {sum_bit, work[WIDTH-1:1]};
                    carry <= carry_nx;
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB on the last bit
                        s    <= {sum_bit, work[WIDTH-1:1]};
                        cout <= carry_nx;
                        ovf  <= carry ^ carry_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be operand A, captured on an accepted start.
REQ-006 b  input  WIDTH  SHALL be operand B, captured on an accepted start.
REQ-007 cin  input  1  SHALL be the carry-in, captured on an accepted start.
REQ-008 sub  input  1  SHALL select the mode, captured on an accepted start: 0 = A+B+cin, 1 = A-B (cin ignored).
REQ-009 busy  output  1  SHALL be high while an operation is in progress (RUN state).
REQ-010 done  output  1  SHALL be a one-cycle pulse marking a new valid result.
REQ-011 s  output  WIDTH  SHALL be the result register.
REQ-012 cout  output  1  SHALL be the carry-out of the MSB position.
REQ-013 ovf  output  1  SHALL flag two's-complement signed overflow of the result.

Function
REQ-014 The datapath SHALL be a single one-bit full adder plus a carry flip-flop, processing one bit per clock, LSB first.
REQ-015 The FSM SHALL have three states: IDLE, RUN, FIN.
- IDLE->RUN on start=1.
- RUN->FIN after exactly WIDTH RUN cycles.
- FIN->IDLE unconditionally after one cycle.
REQ-016 On an accepted start, the block SHALL load A and B shift registers and clear the bit counter to 0.
- Carry flip-flop SHALL load cin when sub=0 and 1 when sub=1.
- When sub=1, B SHALL be stored bitwise inverted.
REQ-017 Each RUN cycle SHALL add the current LSBs and carry.
- The sum bit SHALL shift into the MSB of a working register.
- The carry flip-flop SHALL take the new carry.
- The operand registers SHALL shift right by one.
- The counter SHALL increment.
REQ-018 On entering FIN:
- s SHALL take the working register.
- cout SHALL take the final carry.
- ovf SHALL take the XOR of the carries into and out of the MSB position.
- done SHALL be 1 for exactly that FIN cycle.
REQ-019 Latency SHALL be fixed: done high exactly WIDTH+1 cycles after the clock edge that accepted start; busy high for exactly WIDTH cycles.
REQ-020 start SHALL be ignored in RUN and FIN; no queuing, no effect on the running operation.
REQ-021 start held high continuously SHALL begin a new operation at each return to IDLE (throughput one result per WIDTH+2 cycles).
REQ-022 s, cout and ovf SHALL hold their values between operations and change only on entering FIN.
REQ-023 a, b, cin and sub changing after acceptance SHALL NOT affect the running operation.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH.
- For sub=1, cout=1 SHALL mean no borrow (A>=B unsigned).
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 With rst=1 at a clock edge, the state SHALL become IDLE and busy, done, s, cout, ovf, counter, carry and working registers SHALL all be 0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst asserted during RUN or FIN SHALL abort the operation: no done pulse, and outputs cleared per REQ-026.
REQ-029 The first start SHALL be accepted on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, cin=0, sub=0, start pulse -> busy 8 cycles; done at edge 9; s=0x96, cout=0, ovf=1.
REQ-031 a=0xFF, b=0x00, cin=1, sub=0 -> s=0x00, cout=1, ovf=0; then a=0x7F, b=0x01, cin=0 -> s=0x80, ovf=1.
REQ-032 a=0x10, b=0x20, sub=1 -> s=0xF0, cout=0, ovf=0; then a=0x20, b=0x10, sub=1 -> s=0x10, cout=1.
REQ-033 start pulsed again at RUN cycle 3 with different operands -> ignored; result matches the first operands; exactly one done pulse.
REQ-034 rst asserted at RUN cycle 5 -> no done; all outputs 0 next cycle; new start after rst completes correctly.
REQ-035 Exhaustive sweep, WIDTH=2 and WIDTH=4, all a/b/cin/sub combinations, start held high -> every result matches the reference model; done spacing WIDTH+2.
